// File: rtl/debug_axil_pkg.sv
// Shared definitions for the debug AXI4-Lite master: FSM state type,
// the OKAY response code and the MMIO map of the debug targets.
package debug_axil_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  localparam logic [31:0] UART_TX        = 32'h2000_0000;
  localparam logic [31:0] TIMER          = 32'h2000_0008;
  localparam logic [31:0] COTRL          = 32'h2000_0010;
  localparam logic [31:0] COTRL_COREMARK = 32'h2000_0020;

endpackage

// File: rtl/debug_axil_wdog.sv
// Response watchdog for debug_axil_master (built only with
// DEBUG_AXIL_TIMEOUT_EN).
//   CLK, RSTn : clock, asynchronous active-low reset
//   clr       : request accepted, restart the count
//   en        : a bus transaction is in flight
//   expired   : limit reached; master abandons the transaction
module debug_axil_wdog #(
  parameter int unsigned TMO = 256
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  // The count starts at zero in the first busy cycle; firing at TMO-2 puts
  // the error response exactly TMO cycles after the acceptance cycle.
  localparam int unsigned LIMIT = (TMO > 1) ? TMO - 2 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt >= CW'(LIMIT));

endmodule

// File: rtl/debug_axil_master.sv
// Debug bus bridge: one-at-a-time request/response port to an AXI4-Lite
// master. Optional response watchdog: define DEBUG_AXIL_TIMEOUT_EN.
//   CLK, RSTn          : clock, asynchronous active-low reset
//   req_*              : request (wen=1 write, 0 read), accepted on valid&ready
//   rsp_*              : response, held until rsp_ready
//   M_AW*/M_W*/M_B*    : AXI4-Lite write channels
//   M_AR*/M_R*         : AXI4-Lite read channels
module debug_axil_master
  import debug_axil_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned TMO = 256
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            req_valid,
  input  logic            req_wen,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  input  logic            rsp_ready,
  output logic [AW-1:0]   M_AWADDR,
  output logic            M_AWVALID,
  input  logic            M_AWREADY,
  output logic [DW-1:0]   M_WDATA,
  output logic [DW/8-1:0] M_WSTRB,
  output logic            M_WVALID,
  input  logic            M_WREADY,
  input  logic            M_BVALID,
  input  logic [1:0]      M_BRESP,
  output logic            M_BREADY,
  output logic [AW-1:0]   M_ARADDR,
  output logic            M_ARVALID,
  input  logic            M_ARREADY,
  input  logic            M_RVALID,
  input  logic [DW-1:0]   M_RDATA,
  input  logic [1:0]      M_RRESP,
  output logic            M_RREADY
);

  state_t          state, state_nxt;
  logic            aw_pend, aw_nxt;
  logic            w_pend, w_nxt;
  logic            ar_pend, ar_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [DW/8-1:0] wstrb_q, wstrb_nxt;
  logic [DW-1:0]   rdata_q, rdata_nxt;
  logic            err_q, err_nxt;
  logic            tmo_hit;

`ifdef DEBUG_AXIL_TIMEOUT_EN
  logic accept, busy;

  assign accept = (state == IDLE) && req_valid;
  assign busy   = (state == WADDR) || (state == WRESP) ||
                  (state == RADDR) || (state == RRESP);

  debug_axil_wdog #(.TMO(TMO)) u_wdog (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (accept),
    .en      (busy),
    .expired (tmo_hit)
  );
`else
  // No watchdog: a silent slave stalls the bridge until reset.
  assign tmo_hit = 1'b0;
  if (TMO > 0) begin : g_no_wdog
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_pend <= aw_nxt;
      w_pend  <= w_nxt;
      ar_pend <= ar_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wstrb_q <= wstrb_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    aw_nxt    = aw_pend;
    w_nxt     = w_pend;
    ar_nxt    = ar_pend;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    wstrb_nxt = wstrb_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          wstrb_nxt = req_wstrb;
          if (req_wen) begin
            state_nxt = WADDR;
            aw_nxt    = 1'b1;
            w_nxt     = 1'b1;
          end else begin
            state_nxt = RADDR;
            ar_nxt    = 1'b1;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; leave once both are done.
        if (M_AWREADY) aw_nxt = 1'b0;
        if (M_WREADY)  w_nxt  = 1'b0;
        if (!aw_nxt && !w_nxt) state_nxt = WRESP;
      end
      WRESP: begin
        if (M_BVALID) begin
          rdata_nxt = '0;
          err_nxt   = (M_BRESP != RESP_OKAY);
          state_nxt = DONE;
        end
      end
      RADDR: begin
        if (M_ARREADY) begin
          ar_nxt    = 1'b0;
          state_nxt = RRESP;
        end
      end
      RRESP: begin
        if (M_RVALID) begin
          rdata_nxt = M_RDATA;
          err_nxt   = (M_RRESP != RESP_OKAY);
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_hit) begin
      aw_nxt    = 1'b0;
      w_nxt     = 1'b0;
      ar_nxt    = 1'b0;
      rdata_nxt = '0;
      err_nxt   = 1'b1;
      state_nxt = DONE;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign M_AWADDR  = addr_q;
  assign M_AWVALID = aw_pend;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WVALID  = w_pend;
  assign M_BREADY  = (state == WRESP);
  assign M_ARADDR  = addr_q;
  assign M_ARVALID = ar_pend;
  assign M_RREADY  = (state == RRESP);

endmodule
